// File: rtl/mem_req_master.sv
// Purpose: buffers client memory commands and issues them one at a time to the LFSR-delayed 16x32 memory, returning one response per command.
// Latency: a push into an empty, idle block raises mem_req_o two cycles later; the response pulses the cycle after mem_ready_i is seen.
// Backpressure: cmd_ready_o drops while the command FIFO is full; responses carry no backpressure.
//
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   cmd_valid_i / cmd_ready_o    client command handshake (cmd_rnw_i, cmd_addr_i, cmd_wdata_i)
//   mem_req_o .. mem_wdata_o     request to the memory, held stable until mem_ready_i
//   mem_ready_i, mem_rdata_i     completion and read data from the memory
//   rsp_valid_o .. rsp_lat_o     one-cycle response pulse; fields hold until the next response
//   busy_o                       a command is queued or in flight

// Purpose: generic single-clock FIFO with occupancy counter; no bypass path.
// Latency: a pushed entry is visible at pop_dat from the next cycle.
// Backpressure: push_rdy is low whenever the FIFO is full, even if a pop happens in that cycle.
module mem_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_vld,
    output logic             push_rdy,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_rdy,
    output logic             pop_vld,
    output logic [WIDTH-1:0] pop_dat
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    // Ready depends only on registered occupancy, so a same-cycle pop
    // cannot open a slot for a push.
    assign push_rdy = (count < FULL_CNT);
    assign pop_vld  = (count != '0);
    assign do_push  = push_vld & push_rdy;
    assign do_pop   = pop_rdy & pop_vld;
    assign pop_dat  = store[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            store[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module mem_req_master #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_rnw_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [DATA_W-1:0] cmd_wdata_i,
    output logic              mem_req_o,
    output logic              mem_rnw_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ready_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              rsp_valid_o,
    output logic              rsp_rnw_o,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic [4:0]        rsp_lat_o,
    output logic              busy_o
);
    typedef struct packed {
        logic              rnw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    localparam logic [4:0] LAT_MAX = 5'd31;

    state_t     state_q;
    state_t     state_d;
    cmd_t       push_cmd;
    cmd_t       head_cmd;
    logic       head_vld;
    logic       pop;
    logic       complete;
    logic [4:0] wait_cnt;
    logic [4:0] lat_next;

    assign push_cmd = '{rnw: cmd_rnw_i, addr: cmd_addr_i, wdata: cmd_wdata_i};

    mem_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(cmd_t))
    ) u_cmd_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_vld (cmd_valid_i),
        .push_rdy (cmd_ready_o),
        .push_dat (push_cmd),
        .pop_rdy  (pop),
        .pop_vld  (head_vld),
        .pop_dat  (head_cmd)
    );

    // Completion always passes back through IDLE, which forces at least one
    // low cycle on mem_req_o so the memory sees a fresh rising edge of req.
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        complete  = 1'b0;
        mem_req_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (head_vld) begin
                    pop     = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                mem_req_o = 1'b1;
                if (mem_ready_i) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Cycles with req high for this command, including the completing one.
    assign lat_next = (wait_cnt == LAT_MAX) ? LAT_MAX : wait_cnt + 5'd1;

    assign busy_o = head_vld | (state_q == REQ);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_rnw_o   <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            wait_cnt    <= '0;
            rsp_valid_o <= 1'b0;
            rsp_rnw_o   <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_lat_o   <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_o <= complete;
            if (pop) begin
                mem_rnw_o   <= head_cmd.rnw;
                mem_addr_o  <= head_cmd.addr;
                mem_wdata_o <= head_cmd.wdata;
                wait_cnt    <= '0;
            end else if (state_q == REQ && wait_cnt != LAT_MAX) begin
                wait_cnt <= wait_cnt + 5'd1;
            end
            if (complete) begin
                rsp_rnw_o   <= mem_rnw_o;
                rsp_rdata_o <= mem_rnw_o ? mem_rdata_i : '0;
                rsp_lat_o   <= lat_next;
            end
        end
    end
endmodule

// File: tb/tb_mem_req_master.sv
module tb_mem_req_master;
    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready_o;
    logic        cmd_rnw;
    logic [3:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        mem_req_o;
    logic        mem_rnw_o;
    logic [3:0]  mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        rdy;
    logic [31:0] mem_rdata;
    logic        rsp_valid_o;
    logic        rsp_rnw_o;
    logic [31:0] rsp_rdata_o;
    logic [4:0]  rsp_lat_o;
    logic        busy_o;

    int vectors = 0;
    int miscompares = 0;

    logic        q_rnw[$];
    logic [31:0] q_rdata[$];
    logic [4:0]  q_lat[$];
    logic        log_en = 1'b0;
    logic        req_log[$];
    logic [3:0]  addr_log[$];

    logic [31:0] tmem [16];
    logic [15:0] written;

    mem_req_master #(.DEPTH(4), .ADDR_W(4), .DATA_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready_o),
        .cmd_rnw_i   (cmd_rnw),
        .cmd_addr_i  (cmd_addr),
        .cmd_wdata_i (cmd_wdata),
        .mem_req_o   (mem_req_o),
        .mem_rnw_o   (mem_rnw_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ready_i (rdy),
        .mem_rdata_i (mem_rdata),
        .rsp_valid_o (rsp_valid_o),
        .rsp_rnw_o   (rsp_rnw_o),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_lat_o   (rsp_lat_o),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] base_word(input logic [3:0] a);
        return 32'hC0DE_0000 | {28'd0, a};
    endfunction

    // Simple memory: ready is driven directly by the bench, unwritten words read a fixed pattern.
    assign mem_rdata = written[mem_addr_o] ? tmem[mem_addr_o] : base_word(mem_addr_o);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            written <= '0;
        end else if (mem_req_o && rdy && !mem_rnw_o) begin
            tmem[mem_addr_o]    <= mem_wdata_o;
            written[mem_addr_o] <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rsp_valid_o === 1'b1) begin
            q_rnw.push_back(rsp_rnw_o);
            q_rdata.push_back(rsp_rdata_o);
            q_lat.push_back(rsp_lat_o);
        end
        if (log_en) begin
            req_log.push_back(mem_req_o);
            addr_log.push_back(mem_addr_o);
        end
    end

    task automatic clear_q();
        q_rnw.delete();
        q_rdata.delete();
        q_lat.delete();
    endtask

    task automatic push_cmd(input logic rnw, input logic [3:0] addr, input logic [31:0] wdata);
        cmd_valid = 1'b1;
        cmd_rnw   = rnw;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        for (int i = 0; i < 100 && cmd_ready_o !== 1'b1; i++) @(negedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b0; cmd_rnw = 1'b0; cmd_addr = '0; cmd_wdata = '0; rdy = 1'b0;
        #12;
        vectors++; if (mem_req_o !== 1'b0) begin miscompares++; $display("FAIL rst_req got %b want 0", mem_req_o); end
        vectors++; if (mem_rnw_o !== 1'b0) begin miscompares++; $display("FAIL rst_rnw got %b want 0", mem_rnw_o); end
        vectors++; if (mem_addr_o !== 4'd0) begin miscompares++; $display("FAIL rst_addr got %h want 0", mem_addr_o); end
        vectors++; if (mem_wdata_o !== 32'd0) begin miscompares++; $display("FAIL rst_wdata got %h want 0", mem_wdata_o); end
        vectors++; if (rsp_valid_o !== 1'b0) begin miscompares++; $display("FAIL rst_rsp_valid got %b want 0", rsp_valid_o); end
        vectors++; if (rsp_rnw_o !== 1'b0) begin miscompares++; $display("FAIL rst_rsp_rnw got %b want 0", rsp_rnw_o); end
        vectors++; if (rsp_rdata_o !== 32'd0) begin miscompares++; $display("FAIL rst_rsp_rdata got %h want 0", rsp_rdata_o); end
        vectors++; if (rsp_lat_o !== 5'd0) begin miscompares++; $display("FAIL rst_rsp_lat got %0d want 0", rsp_lat_o); end
        vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b want 0", busy_o); end
        vectors++; if (cmd_ready_o !== 1'b1) begin miscompares++; $display("FAIL rst_cmd_ready got %b want 1", cmd_ready_o); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_req_gap();
        int highs;
        int consec;
        int addr_err;
        rdy = 1'b1;
        clear_q();
        req_log.delete();
        addr_log.delete();
        log_en = 1'b1;
        for (int i = 0; i < 8; i++) push_cmd(1'b1, 4'(i), 32'd0);
        repeat (12) @(negedge clk);
        log_en = 1'b0;
        highs = 0; consec = 0; addr_err = 0;
        for (int i = 0; i < req_log.size(); i++) begin
            if (req_log[i] === 1'b1) begin
                if (i > 0 && req_log[i-1] === 1'b1) consec++;
                if (addr_log[i] !== 4'(highs)) addr_err++;
                highs++;
            end
        end
        vectors++; if (highs != 8) begin miscompares++; $display("FAIL gap_req_cycles got %0d want 8", highs); end
        vectors++; if (consec != 0) begin miscompares++; $display("FAIL gap_consecutive_high got %0d want 0", consec); end
        vectors++; if (addr_err != 0) begin miscompares++; $display("FAIL gap_addr_order got %0d bad want 0", addr_err); end
        vectors++; if (q_rdata.size() != 8) begin miscompares++; $display("FAIL gap_rsp_count got %0d want 8", q_rdata.size()); end
        for (int i = 0; i < q_rdata.size() && i < 8; i++) begin
            vectors++; if (q_lat[i] !== 5'd1) begin miscompares++; $display("FAIL gap_lat[%0d] got %0d want 1", i, q_lat[i]); end
            vectors++; if (q_rdata[i] !== base_word(4'(i))) begin miscompares++; $display("FAIL gap_rdata[%0d] got %h want %h", i, q_rdata[i], base_word(4'(i))); end
        end
    endtask

    task automatic test_write_read();
        rdy = 1'b1;
        clear_q();
        push_cmd(1'b0, 4'd3, 32'hDEAD_BEEF);
        vectors++; if (mem_req_o !== 1'b0) begin miscompares++; $display("FAIL wr_issue_t1 got %b want 0", mem_req_o); end
        @(negedge clk);
        vectors++; if (mem_req_o !== 1'b1) begin miscompares++; $display("FAIL wr_issue_t2 got %b want 1", mem_req_o); end
        vectors++; if (mem_addr_o !== 4'd3) begin miscompares++; $display("FAIL wr_addr got %h want 3", mem_addr_o); end
        vectors++; if (mem_wdata_o !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL wr_wdata got %h want deadbeef", mem_wdata_o); end
        vectors++; if (mem_rnw_o !== 1'b0) begin miscompares++; $display("FAIL wr_rnw got %b want 0", mem_rnw_o); end
        @(negedge clk);
        vectors++; if (rsp_valid_o !== 1'b1) begin miscompares++; $display("FAIL wr_rsp_valid got %b want 1", rsp_valid_o); end
        vectors++; if (mem_req_o !== 1'b0) begin miscompares++; $display("FAIL wr_req_after got %b want 0", mem_req_o); end
        vectors++; if (rsp_rdata_o !== 32'd0) begin miscompares++; $display("FAIL wr_rsp_rdata got %h want 0", rsp_rdata_o); end
        vectors++; if (rsp_lat_o !== 5'd1) begin miscompares++; $display("FAIL wr_rsp_lat got %0d want 1", rsp_lat_o); end
        push_cmd(1'b1, 4'd3, 32'd0);
        repeat (6) @(negedge clk);
        vectors++; if (q_rdata.size() != 2) begin miscompares++; $display("FAIL wr_rd_count got %0d want 2", q_rdata.size()); end
        if (q_rdata.size() == 2) begin
            vectors++; if (q_rnw[0] !== 1'b0) begin miscompares++; $display("FAIL wr_rd_first_rnw got %b want 0", q_rnw[0]); end
            vectors++; if (q_rnw[1] !== 1'b1) begin miscompares++; $display("FAIL wr_rd_second_rnw got %b want 1", q_rnw[1]); end
            vectors++; if (q_rdata[1] !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL wr_rd_rdata got %h want deadbeef", q_rdata[1]); end
        end
    endtask

    task automatic test_latency();
        rdy = 1'b0;
        push_cmd(1'b1, 4'd9, 32'd0);
        for (int i = 0; i < 20 && mem_req_o !== 1'b1; i++) @(negedge clk);
        vectors++; if (mem_req_o !== 1'b1) begin miscompares++; $display("FAIL lat_issue got %b want 1", mem_req_o); end
        repeat (9) @(negedge clk);
        rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
        vectors++; if (rsp_valid_o !== 1'b1) begin miscompares++; $display("FAIL lat10_valid got %b want 1", rsp_valid_o); end
        vectors++; if (rsp_lat_o !== 5'd10) begin miscompares++; $display("FAIL lat10_value got %0d want 10", rsp_lat_o); end
        vectors++; if (rsp_rdata_o !== base_word(4'd9)) begin miscompares++; $display("FAIL lat10_rdata got %h want %h", rsp_rdata_o, base_word(4'd9)); end
        @(negedge clk);
        vectors++; if (rsp_valid_o !== 1'b0) begin miscompares++; $display("FAIL lat_pulse_width got %b want 0", rsp_valid_o); end
        vectors++; if (rsp_lat_o !== 5'd10) begin miscompares++; $display("FAIL lat_hold got %0d want 10", rsp_lat_o); end
        push_cmd(1'b1, 4'd10, 32'd0);
        for (int i = 0; i < 20 && mem_req_o !== 1'b1; i++) @(negedge clk);
        repeat (40) @(negedge clk);
        rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
        vectors++; if (rsp_lat_o !== 5'd31) begin miscompares++; $display("FAIL lat_sat got %0d want 31", rsp_lat_o); end
        @(negedge clk);
    endtask

    task automatic test_fill();
        rdy = 1'b0;
        clear_q();
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1; cmd_rnw = 1'b1; cmd_addr = 4'(4 + i); cmd_wdata = 32'(i);
            vectors++; if (cmd_ready_o !== 1'b1) begin miscompares++; $display("FAIL fill_accept[%0d] got %b want 1", i, cmd_ready_o); end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        vectors++; if (cmd_ready_o !== 1'b0) begin miscompares++; $display("FAIL fill_full got %b want 0", cmd_ready_o); end
        vectors++; if (mem_req_o !== 1'b1) begin miscompares++; $display("FAIL fill_req got %b want 1", mem_req_o); end
        vectors++; if (busy_o !== 1'b1) begin miscompares++; $display("FAIL fill_busy got %b want 1", busy_o); end
        repeat (6) @(negedge clk);
        vectors++; if (mem_req_o !== 1'b1) begin miscompares++; $display("FAIL fill_req_held got %b want 1", mem_req_o); end
        vectors++; if (mem_addr_o !== 4'd4) begin miscompares++; $display("FAIL fill_addr_stable got %h want 4", mem_addr_o); end
        vectors++; if (mem_wdata_o !== 32'd0) begin miscompares++; $display("FAIL fill_wdata_stable got %h want 0", mem_wdata_o); end
        rdy = 1'b1;
        repeat (20) @(negedge clk);
        vectors++; if (q_rdata.size() != 5) begin miscompares++; $display("FAIL fill_rsp_count got %0d want 5", q_rdata.size()); end
        for (int i = 0; i < q_rdata.size() && i < 5; i++) begin
            vectors++; if (q_rdata[i] !== base_word(4'(4 + i))) begin miscompares++; $display("FAIL fill_order[%0d] got %h want %h", i, q_rdata[i], base_word(4'(4 + i))); end
        end
        vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL fill_drained_busy got %b want 0", busy_o); end
    endtask

    task automatic test_full_push_pop();
        logic [3:0] exp_addr [6];
        rdy = 1'b0;
        clear_q();
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1; cmd_rnw = 1'b1; cmd_addr = 4'(8 + i); cmd_wdata = '0;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        rdy = 1'b1;
        @(negedge clk);
        // Completion cycle has passed; this cycle the head is popped while still full.
        rdy = 1'b0;
        cmd_valid = 1'b1; cmd_rnw = 1'b1; cmd_addr = 4'd15;
        vectors++; if (rsp_valid_o !== 1'b1) begin miscompares++; $display("FAIL pp_rsp_valid got %b want 1", rsp_valid_o); end
        vectors++; if (cmd_ready_o !== 1'b0) begin miscompares++; $display("FAIL pp_refused got %b want 0", cmd_ready_o); end
        @(negedge clk);
        vectors++; if (cmd_ready_o !== 1'b1) begin miscompares++; $display("FAIL pp_reopen got %b want 1", cmd_ready_o); end
        @(negedge clk);
        cmd_valid = 1'b0;
        rdy = 1'b1;
        repeat (25) @(negedge clk);
        exp_addr = '{4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd15};
        vectors++; if (q_rdata.size() != 6) begin miscompares++; $display("FAIL pp_rsp_count got %0d want 6", q_rdata.size()); end
        for (int i = 0; i < q_rdata.size() && i < 6; i++) begin
            vectors++; if (q_rdata[i] !== base_word(exp_addr[i])) begin miscompares++; $display("FAIL pp_order[%0d] got %h want %h", i, q_rdata[i], base_word(exp_addr[i])); end
        end
    endtask

    task automatic test_reset_mid();
        rdy = 1'b0;
        push_cmd(1'b1, 4'd1, 32'd0);
        push_cmd(1'b1, 4'd2, 32'd0);
        push_cmd(1'b1, 4'd5, 32'd0);
        vectors++; if (mem_req_o !== 1'b1) begin miscompares++; $display("FAIL rm_pre_req got %b want 1", mem_req_o); end
        reset = 1'b1;
        #1;
        clear_q();
        vectors++; if (mem_req_o !== 1'b0) begin miscompares++; $display("FAIL rm_req got %b want 0", mem_req_o); end
        vectors++; if (mem_addr_o !== 4'd0) begin miscompares++; $display("FAIL rm_addr got %h want 0", mem_addr_o); end
        vectors++; if (mem_rnw_o !== 1'b0) begin miscompares++; $display("FAIL rm_rnw got %b want 0", mem_rnw_o); end
        vectors++; if (rsp_rdata_o !== 32'd0) begin miscompares++; $display("FAIL rm_rsp_rdata got %h want 0", rsp_rdata_o); end
        vectors++; if (rsp_lat_o !== 5'd0) begin miscompares++; $display("FAIL rm_rsp_lat got %0d want 0", rsp_lat_o); end
        vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL rm_busy got %b want 0", busy_o); end
        vectors++; if (cmd_ready_o !== 1'b1) begin miscompares++; $display("FAIL rm_cmd_ready got %b want 1", cmd_ready_o); end
        @(negedge clk);
        reset = 1'b0;
        rdy = 1'b1;
        repeat (12) @(negedge clk);
        vectors++; if (q_rdata.size() != 0) begin miscompares++; $display("FAIL rm_no_rsp got %0d want 0", q_rdata.size()); end
        vectors++; if (mem_req_o !== 1'b0) begin miscompares++; $display("FAIL rm_req_after got %b want 0", mem_req_o); end
        vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL rm_busy_after got %b want 0", busy_o); end
    endtask

    initial begin
        test_reset();
        test_req_gap();
        test_write_read();
        test_latency();
        test_fill();
        test_full_push_pop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
